// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, derived totals and the per-axis region decode.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   typedef struct packed {
      logic in_sync;
      logic in_active;
      logic at_start;
   } axis_region_t;

   function automatic int axis_total(input int sync_w, input int bp_w,
                                     input int act_w, input int fp_w);
      return sync_w + bp_w + act_w + fp_w;
   endfunction

   function automatic int cnt_width(input int total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

   localparam int DEF_H_TOTAL = axis_total(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP);
   localparam int DEF_V_TOTAL = axis_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP);

   // Axis order is sync, back porch, active, front porch; bounds are elaboration constants.
   function automatic axis_region_t decode_axis(input int unsigned pos,
                                                input int unsigned sync_w,
                                                input int unsigned bp_w,
                                                input int unsigned act_w);
      axis_region_t r;
      r.in_sync   = (pos < sync_w);
      r.in_active = (pos >= sync_w + bp_w) && (pos < sync_w + bp_w + act_w);
      r.at_start  = (pos == 32'd0);
      return r;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one display axis: steps on advance, returns to 0 after TOTAL-1.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL = DEF_H_TOTAL,
   parameter int CNT_W = cnt_width(DEF_H_TOTAL)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             advance,
   output logic [CNT_W-1:0] count,
   output logic             terminal
);

   assign terminal = (count == CNT_W'(TOTAL - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (advance) begin
         count <= terminal ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: prescaled h/v counters feeding a two-stage output pipeline.
// column/row lead de/o_rgb by one pixel so user colour logic can be purely combinational.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic H_POL    = 1'b0,
   parameter logic V_POL    = 1'b0,
   parameter int   CLK_DIV  = 2,
   parameter int   RGB_W    = 3,
   parameter int   COL_W    = 10,
   parameter int   ROW_W    = 9
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [RGB_W-1:0] rgb,
   output logic [COL_W-1:0] column,
   output logic [ROW_W-1:0] row,
   output logic             h_sync,
   output logic             v_sync,
   output logic             de,
   output logic [RGB_W-1:0] o_rgb,
   output logic             line_start,
   output logic             frame_start
);

   localparam int H_TOTAL     = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
   localparam int V_TOTAL     = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
   localparam int HC_W        = cnt_width(H_TOTAL);
   localparam int VC_W        = cnt_width(V_TOTAL);
   localparam int H_ACT_START = H_SYNC + H_BP;
   localparam int V_ACT_START = V_SYNC + V_BP;
   localparam int DIV_W       = 5;

   logic [DIV_W-1:0] div_cnt;
   logic             pix_ce;

   logic [HC_W-1:0]  h_count;
   logic [VC_W-1:0]  v_count;
   logic             h_term;
   logic             v_term_unused;
   axis_region_t     h_reg;
   axis_region_t     v_reg;
   logic             vis;

   logic [COL_W-1:0] col_p1;
   logic [ROW_W-1:0] row_p1;
   logic             vld_p1;
   logic             hs_p1;
   logic             vs_p1;
   logic             ls_p1;
   logic             fs_p1;

   logic             vld_p2;
   logic             hs_p2;
   logic             vs_p2;
   logic             ls_p2;
   logic             fs_p2;
   logic [RGB_W-1:0] rgb_p2;

   // With CLK_DIV=1 the terminal value is 0, so pix_ce stays high.
   assign pix_ce = (div_cnt == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= pix_ce ? '0 : div_cnt + DIV_W'(1);
      end
   end

   vga_axis_counter #(
      .TOTAL (H_TOTAL),
      .CNT_W (HC_W)
   ) u_h_counter (
      .clock    (clock),
      .reset    (reset),
      .advance  (pix_ce),
      .count    (h_count),
      .terminal (h_term)
   );

   vga_axis_counter #(
      .TOTAL (V_TOTAL),
      .CNT_W (VC_W)
   ) u_v_counter (
      .clock    (clock),
      .reset    (reset),
      .advance  (pix_ce & h_term),
      .count    (v_count),
      .terminal (v_term_unused)
   );

   assign h_reg = decode_axis(32'(h_count), H_SYNC, H_BP, H_ACTIVE);
   assign v_reg = decode_axis(32'(v_count), V_SYNC, V_BP, V_ACTIVE);
   assign vis   = h_reg.in_active & v_reg.in_active;

   // Stage 1: coordinates and region flags for the pixel at (h_count, v_count)
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_p1 <= '0;
         row_p1 <= '0;
         vld_p1 <= 1'b0;
         hs_p1  <= ~H_POL;
         vs_p1  <= ~V_POL;
         ls_p1  <= 1'b0;
         fs_p1  <= 1'b0;
      end else if (pix_ce) begin
         col_p1 <= vis ? COL_W'(32'(h_count) - 32'(H_ACT_START)) : '0;
         row_p1 <= vis ? ROW_W'(32'(v_count) - 32'(V_ACT_START)) : '0;
         vld_p1 <= vis;
         hs_p1  <= h_reg.in_sync ? H_POL : ~H_POL;
         vs_p1  <= v_reg.in_sync ? V_POL : ~V_POL;
         ls_p1  <= h_reg.at_start;
         fs_p1  <= h_reg.at_start & v_reg.at_start;
      end
   end

   // Stage 2: sync/enable outputs, colour captured from user logic driven by column/row
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_p2 <= 1'b0;
         hs_p2  <= ~H_POL;
         vs_p2  <= ~V_POL;
         ls_p2  <= 1'b0;
         fs_p2  <= 1'b0;
         rgb_p2 <= '0;
      end else if (pix_ce) begin
         vld_p2 <= vld_p1;
         hs_p2  <= hs_p1;
         vs_p2  <= vs_p1;
         ls_p2  <= ls_p1;
         fs_p2  <= fs_p1;
         rgb_p2 <= vld_p1 ? rgb : '0;
      end
   end

   assign column      = col_p1;
   assign row         = row_p1;
   assign de          = vld_p2;
   assign h_sync      = hs_p2;
   assign v_sync      = vs_p2;
   assign line_start  = ls_p2;
   assign frame_start = fs_p2;
   assign o_rgb       = rgb_p2;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
  H_ACTIVE 640 visible pixels per line
  H_FP 16 horizontal front porch, pixels
  H_SYNC 96 horizontal sync width, pixels
  H_BP 48 horizontal back porch, pixels
  V_ACTIVE 480 visible lines per frame
  V_FP 10 vertical front porch, lines
  V_SYNC 2 vertical sync width, lines
  V_BP 33 vertical back porch, lines
  H_POL 0 h_sync active level
  V_POL 0 v_sync active level
  CLK_DIV 2 clock cycles per pixel, 1..16
  RGB_W 3 colour bus width
  COL_W 10 column width; SHALL hold H_ACTIVE-1
  ROW_W 9 row width; SHALL hold V_ACTIVE-1
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
  clock in 1 single system clock, rising edge
  reset in 1 asynchronous, active-low reset
  rgb in RGB_W pixel colour for the current column/row
  column out COL_W active-area x coordinate; 0 in blanking
  row out ROW_W active-area y coordinate; 0 in blanking
  h_sync out 1 horizontal sync at level H_POL while active
  v_sync out 1 vertical sync at level V_POL while active
  de out 1 data enable, high for visible pixels
  o_rgb out RGB_W colour to the DAC; 0 when de=0
  line_start out 1 one-pixel pulse on h_count==0
  frame_start out 1 one-pixel pulse on h_count==0 and v_count==0

Function
REQ-003 Prescaler: pix_ce SHALL pulse for 1 clock every CLK_DIV clocks; CLK_DIV=1 -> pix_ce held high.
REQ-004 h_count SHALL advance only on pix_ce, over 0..H_TOTAL-1 where H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP, and SHALL wrap to 0.
REQ-005 v_count SHALL advance only on the pix_ce that wraps h_count, over 0..V_TOTAL-1, and SHALL wrap to 0; a simultaneous h and v wrap SHALL take both counters to 0 on the same edge.
REQ-006 Region order per axis: sync [0,SYNC), back porch, active [SYNC+BP, SYNC+BP+ACTIVE), front porch.
REQ-007 Stage 1 (on pix_ce) SHALL register column=h_count-(H_SYNC+H_BP) and row=v_count-(V_SYNC+V_BP) when both axes are active (otherwise 0), plus internal de1, hs1, vs1, ls1, fs1.
REQ-008 Stage 2 (on pix_ce) SHALL register h_sync, v_sync, de, line_start, frame_start from stage 1, and o_rgb <= de1 ? rgb : 0.
REQ-009 column/row SHALL lead de/o_rgb by exactly one pixel, so user logic drives rgb combinationally from column/row.
REQ-010 All outputs SHALL change only on clock edges where pix_ce=1; between pix_ce edges they SHALL hold.
REQ-011 Pulses line_start and frame_start SHALL be exactly one pixel period (CLK_DIV clocks) wide and aligned with de.

Reset
REQ-012 reset=0 SHALL clear the prescaler, h_count, v_count and both pipeline stages asynchronously, mid-frame included.
REQ-013 Reset values: column=0, row=0, de=0, o_rgb=0, line_start=0, frame_start=0, h_sync=~H_POL, v_sync=~V_POL.
REQ-014 After reset release, the first pix_ce SHALL process h_count=0, v_count=0; frame_start SHALL rise on the second pix_ce.

Structure
REQ-015 The default 640x480@60 timing constants and the derived H_TOTAL and V_TOTAL expressions SHALL live in a shared package, vga_timing_pkg.
REQ-016 One sub-module, vga_axis_counter (parametric wrapping counter with advance input and terminal-count output), SHALL be instantiated twice, once for h and once for v.
REQ-017 No multipliers; region decode SHALL use constant comparisons only.

Verification
REQ-018 Defaults, CLK_DIV=2: h_sync low for 192 clocks per 1600-clock line; v_sync low for 2 lines per 525.
REQ-019 Small parameters H 4/1/2/1 and V 3/1/1/1, CLK_DIV=1: de high for 4 consecutive clocks per 8-clock line on 3 of 6 lines; column sequence 0,1,2,3.
REQ-020 rgb=column[2:0]: o_rgb SHALL equal the column value from one clock earlier while de=1, and 0 while de=0.
REQ-021 Assert reset mid-active-line: on the same clock h_sync=~H_POL, de=0, o_rgb=0; after release, frame_start SHALL appear on the 2nd pix_ce.
REQ-022 H_POL=1, V_POL=1: sync polarity inverted, timing unchanged; frame_start SHALL pulse once per V_TOTAL*H_TOTAL pix_ce.
